mem_block_mover: RTL and testbench
==================================

# mem_block_mover

Bus master for the coprocessor's multi-word `memory` block. It converts between a word-serial stream (one `cell_width` word per handshake) and the memory's `blocks`-wide line port. On the write path it packs incoming words into lines and issues write strobes. On the read path it issues read strobes, captures each returned line and serialises it out as words. It sits between the coprocessor datapath or loader and the memory, and replaces testbench-style direct driving of the memory port.

## Interface
- `blocks`, default 4: words per memory line.
- `cell_width`, default 32: bits per word.
- `log_size`, default 10: memory address width.
- `cnt_width`, default 8: width of the line-count field.
- `width` (localparam) = `blocks*cell_width`.
- `in_clk` input 1: clock. All logic is on the rising edge.
- `in_reset` input 1: reset. Asynchronous, active-low.
- `in_start` input 1: command strobe. Sampled only in IDLE.
- `in_dir` input 1: direction. 0 = stream to memory (write); 1 = memory to stream (read).
- `in_base_addr` input `log_size`: word address of the first line.
- `in_lines` input `cnt_width`: number of lines to transfer.
- `out_busy` output 1: high whenever state is not IDLE.
- `out_done` output 1: one-cycle pulse when a command completes.
- `in_word` input `cell_width`: write-stream data.
- `in_word_valid` input 1: write-stream valid.
- `out_word_ready` output 1: write-stream ready.
- `out_word` output `cell_width`: read-stream data.
- `out_word_valid` output 1: read-stream valid.
- `in_word_ready` input 1: read-stream ready.
- `out_mem_address` output `log_size`: drives memory `in_address`.
- `out_mem_data` output `width`: drives memory `in_data`.
- `out_mem_read_en` output 1: drives memory `in_read_en`.
- `out_mem_write_en` output 1: drives memory `in_write_en`.
- `in_mem_data` input `width`: memory `out_data`.

## Operation
- States: IDLE, FILL, WRITE, RD_REQ, RD_WAIT, DRAIN, DONE.
- Reset values: all outputs 0, state IDLE. This includes `out_mem_data`, `out_mem_address` and `out_word`.
- IDLE:
  - On `in_start`, latch `in_dir`, `in_base_addr` and `in_lines`, and clear the word index.
  - If `in_lines`=0, go to DONE.
  - Otherwise go to FILL (dir 0) or RD_REQ (dir 1).
- FILL:
  - `out_word_ready`=1.
  - Each `in_word_valid`&`out_word_ready` stores `in_word` into `out_mem_data[idx*cell_width +: cell_width]`, then idx++.
  - Word 0 lands in the lowest bits, i.e. the lowest memory address.
  - After word `blocks-1` is accepted, go to WRITE.
- WRITE:
  - Exactly one cycle: `out_mem_write_en`=1, `out_word_ready`=0.
  - Then address += `blocks`, lines--, and go to FILL if lines remain, else DONE.
- RD_REQ: exactly one cycle, `out_mem_read_en`=1.
- RD_WAIT:
  - One cycle; the memory's registered data is valid during this cycle.
  - At the end of the cycle, capture `in_mem_data` into the line buffer and go to DRAIN.
- DRAIN:
  - `out_word_valid`=1, `out_word` = buffer word idx.
  - Each `out_word_valid`&`in_word_ready` increments idx.
  - After word `blocks-1` is taken: address += `blocks`, lines--, then go to RD_REQ if lines remain, else DONE.
- DONE: `out_done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^`log_size`. Wrap-around is silent, with no error.
- The block does not guard against `base + blocks` exceeding memory `size`.
- `out_mem_read_en` and `out_mem_write_en` are never high in the same cycle.
- `in_start` while busy is ignored.
- Reset mid-operation: immediate return to IDLE. The partially packed line is discarded and no write is issued.
- Stream stalls (valid or ready low) hold all state indefinitely and have no timeout.

## Timing
- Memory strobes, address and data are registered outputs. They are stable for the whole strobe cycle.
- Write path:
  - Best case is `blocks`+1 cycles per line.
  - The first `out_word_ready` comes the cycle after `in_start`.
- Read path:
  - Best case is 2+`blocks` cycles per line.
  - The first `out_word_valid` appears 3 cycles after the `in_start` cycle.
- `out_done` is asserted the cycle after the last WRITE strobe or the last DRAIN handshake.
- `out_busy` falls in the same cycle that `out_done` falls.
- `out_word` is held stable while `out_word_valid`=1 and `in_word_ready`=0.

## Test plan
- **Write, 2 lines at base 0x010.** Stream 0x11..0x18 with valid held high.
  - Expect strobes at address 0x010 and 0x014.
  - Expect `out_mem_data`=0x00000014_00000013_00000012_00000011, then the 0x18..0x15 line.
  - Expect one `out_done` pulse.
- **Read back the same 2 lines** through the real `memory` model with `in_word_ready` held high.
  - Expect `out_word` sequence 0x11..0x18.
  - Expect read strobes at 0x010 and 0x014, 6 cycles apart.
- **Backpressure.** During a read, drop `in_word_ready` for 3 cycles mid-line.
  - `out_word` holds.
  - No new `out_mem_read_en` is issued until the line is drained.
- **Wrap-around.** Base 0x3FC (`log_size`=10), 2 lines.
  - Second strobe address is 0x000.
- **Zero length.** `in_lines`=0.
  - `out_done` is asserted 1 cycle after start.
  - No memory strobe occurs.
  - `out_busy` is high for exactly 1 cycle.
- **Reset during FILL, after 2 words.**
  - All outputs are 0 asynchronously and no write strobe follows.
  - A new command afterwards works normally.
  - `in_start` pulsed during that command is ignored.

Source files
------------

// File: rtl/mem_block_mover.sv
// mem_block_mover
// Bus master for the multi-word memory block. Converts between a word-serial
// stream (one cell_width word per handshake) and the memory's blocks-wide line
// port.
//   Write (in_dir=0): packs in_word stream into a line, then one write strobe.
//   Read  (in_dir=1): one read strobe, capture the returned line one cycle
//                     later, then serialise it out as words.
// Ports:
//   in_clk, in_reset            clock, async active-low reset
//   in_start/in_dir/in_base_addr/in_lines   command (sampled only in IDLE)
//   out_busy, out_done          status (done is a one-cycle pulse)
//   in_word/in_word_valid/out_word_ready    write-stream sink
//   out_word/out_word_valid/in_word_ready   read-stream source
//   out_mem_*/in_mem_data       memory line port (all outputs registered)
module mem_block_mover #(
  parameter  int blocks     = 4,
  parameter  int cell_width = 32,
  parameter  int log_size   = 10,
  parameter  int cnt_width  = 8,
  localparam int width      = blocks * cell_width
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_start,
  input  logic                  in_dir,
  input  logic [log_size-1:0]   in_base_addr,
  input  logic [cnt_width-1:0]  in_lines,
  output logic                  out_busy,
  output logic                  out_done,
  input  logic [cell_width-1:0] in_word,
  input  logic                  in_word_valid,
  output logic                  out_word_ready,
  output logic [cell_width-1:0] out_word,
  output logic                  out_word_valid,
  input  logic                  in_word_ready,
  output logic [log_size-1:0]   out_mem_address,
  output logic [width-1:0]      out_mem_data,
  output logic                  out_mem_read_en,
  output logic                  out_mem_write_en,
  input  logic [width-1:0]      in_mem_data
);

  localparam int                  IW   = (blocks > 1) ? $clog2(blocks) : 1;
  localparam logic [IW-1:0]       LAST = IW'(blocks - 1);
  localparam logic [log_size-1:0] STEP = log_size'(blocks);

  // IDLE encodes as 0 so every state-decoded output is 0 in reset.
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_RD_REQ, S_RD_WAIT, S_DRAIN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [log_size-1:0]   addr_q, addr_d;
  logic [cnt_width-1:0]  lines_q, lines_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [width-1:0]      wbuf_q, wbuf_d;   // line being packed, drives memory data
  logic [width-1:0]      rbuf_q, rbuf_d;   // captured read line being drained
  logic [31:0]           word_off;

  assign word_off = 32'(idx_q) * 32'(cell_width);

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lines_q <= '0;
      idx_q   <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lines_q <= lines_d;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Direction is not kept in a separate register: after IDLE the state
  // itself (FILL/WRITE vs RD_REQ/RD_WAIT/DRAIN) carries it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lines_d = lines_q;
    idx_d   = idx_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          addr_d  = in_base_addr;
          lines_d = in_lines;
          idx_d   = '0;
          if (in_lines == '0) state_d = S_DONE;
          else                state_d = in_dir ? S_RD_REQ : S_FILL;
        end
      end
      S_FILL: begin
        if (in_word_valid) begin
          wbuf_d[word_off +: cell_width] = in_word;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + STEP;          // wraps modulo 2^log_size
        lines_d = lines_q - cnt_width'(1);
        state_d = (lines_q == cnt_width'(1)) ? S_DONE : S_FILL;
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // memory output register holds the requested line in this cycle
        rbuf_d  = in_mem_data;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (in_word_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            addr_d  = addr_q + STEP;
            lines_d = lines_q - cnt_width'(1);
            state_d = (lines_q == cnt_width'(1)) ? S_DONE : S_RD_REQ;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode registered state only, so they are glitch-free and
  // stable for the whole cycle.
  assign out_busy         = (state_q != S_IDLE);
  assign out_done         = (state_q == S_DONE);
  assign out_word_ready   = (state_q == S_FILL);
  assign out_word_valid   = (state_q == S_DRAIN);
  assign out_mem_write_en = (state_q == S_WRITE);
  assign out_mem_read_en  = (state_q == S_RD_REQ);
  assign out_mem_address  = addr_q;
  assign out_mem_data     = wbuf_q;
  assign out_word         = rbuf_q[word_off +: cell_width];

endmodule

// File: tb/tb_mem_block_mover.sv
// Testbench for mem_block_mover: directed commands, a word-addressed memory
// model, a transaction scoreboard checked every cycle, and literal timing and
// data expectations for each scenario.
module tb_mem_block_mover;
  localparam int BL = 4, CW = 32, LS = 10, CN = 8, W = BL * CW;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          in_start = 0, in_dir = 0;
  logic [LS-1:0] in_base_addr = '0;
  logic [CN-1:0] in_lines = '0;
  logic          out_busy, out_done;
  logic [CW-1:0] in_word = '0;
  logic          in_word_valid = 0, out_word_ready;
  logic [CW-1:0] out_word;
  logic          out_word_valid, in_word_ready = 0;
  logic [LS-1:0] out_mem_address;
  logic [W-1:0]  out_mem_data, mem_rdata;
  logic          out_mem_read_en, out_mem_write_en;

  mem_block_mover #(.blocks(BL), .cell_width(CW), .log_size(LS), .cnt_width(CN)) dut (
    .in_clk(clk), .in_reset(rst_n), .in_start(in_start), .in_dir(in_dir),
    .in_base_addr(in_base_addr), .in_lines(in_lines), .out_busy(out_busy),
    .out_done(out_done), .in_word(in_word), .in_word_valid(in_word_valid),
    .out_word_ready(out_word_ready), .out_word(out_word),
    .out_word_valid(out_word_valid), .in_word_ready(in_word_ready),
    .out_mem_address(out_mem_address), .out_mem_data(out_mem_data),
    .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
    .in_mem_data(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Memory: word addressed, line access wraps modulo 2^LS, registered read.
  logic [CW-1:0] mem [1 << LS];
  always @(posedge clk) begin
    if (out_mem_write_en)
      for (int k = 0; k < BL; k++) mem[out_mem_address + LS'(k)] <= out_mem_data[k*CW +: CW];
    if (out_mem_read_en)
      for (int k = 0; k < BL; k++) mem_rdata[k*CW +: CW] <= mem[out_mem_address + LS'(k)];
  end

  // Reference contents and expected transactions.
  logic [CW-1:0] ref_mem [1 << LS];
  logic [LS-1:0] exp_wa[$], exp_ra[$];
  logic [W-1:0]  exp_wd[$];
  logic [CW-1:0] exp_words[$];

  // Observed logs.
  int            wr_cyc[$], rd_cyc[$];
  logic [LS-1:0] wr_addr[$];
  logic [W-1:0]  wr_data[$];
  logic [CW-1:0] wd_log[$];
  int            busy_cnt = 0, done_cnt = 0;

  // Per-cycle compare process.
  logic          prev_v = 0, prev_r = 0;
  logic [CW-1:0] prev_w = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      if (out_mem_read_en || out_mem_write_en)
        chk("strobe_exclusive", W'(out_mem_read_en & out_mem_write_en), '0);
      if (out_mem_write_en) begin
        wr_cyc.push_back(cyc); wr_addr.push_back(out_mem_address); wr_data.push_back(out_mem_data);
        if (exp_wa.size() == 0) chk("unexpected_write", W'(out_mem_address), '1);
        else begin
          chk("wr_addr", W'(out_mem_address), W'(exp_wa.pop_front()));
          chk("wr_data", out_mem_data, exp_wd.pop_front());
        end
      end
      if (out_mem_read_en) begin
        rd_cyc.push_back(cyc);
        if (exp_ra.size() == 0) chk("unexpected_read", W'(out_mem_address), '1);
        else chk("rd_addr", W'(out_mem_address), W'(exp_ra.pop_front()));
      end
      if (out_word_valid && in_word_ready) begin
        wd_log.push_back(out_word);
        if (exp_words.size() == 0) chk("unexpected_word", W'(out_word), '1);
        else chk("rd_word", W'(out_word), W'(exp_words.pop_front()));
      end
      if (prev_v && !prev_r && out_word_valid) chk("word_hold", W'(out_word), W'(prev_w));
      if (out_done) chk("done_while_busy", W'(out_busy), W'(1));
      if (out_busy) busy_cnt++;
      if (out_done) done_cnt++;
      prev_v = out_word_valid; prev_r = in_word_ready; prev_w = out_word;
    end
  end

  // Issue one command and run it to out_done. stall drops in_word_ready in
  // cycles start+5..start+7; glitch pulses in_start at start+3.
  task automatic run_cmd(input bit dir, input logic [LS-1:0] base, input int lines,
                         input int first, input bit stall, input bit glitch,
                         output int t0, output int tdone, output int tfr, output int tfv);
    int i = 0, n = lines * BL;
    bit fin = 0;
    for (int l = 0; l < lines; l++) begin
      logic [LS-1:0] a = base + LS'(BL * l);
      logic [W-1:0]  d;
      if (!dir) begin
        for (int k = 0; k < BL; k++) begin
          d[k*CW +: CW] = CW'(first + BL * l + k);
          ref_mem[a + LS'(k)] = CW'(first + BL * l + k);
        end
        exp_wa.push_back(a); exp_wd.push_back(d);
      end else begin
        exp_ra.push_back(a);
        for (int k = 0; k < BL; k++) exp_words.push_back(ref_mem[a + LS'(k)]);
      end
    end
    tdone = -1; tfr = -1; tfv = -1;
    @(posedge clk); #1;
    in_start = 1; in_dir = dir; in_base_addr = base; in_lines = CN'(lines); t0 = cyc;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (c > 0) in_start = (glitch && c == 3);
      if (glitch && c == 3) begin in_dir = 1; in_lines = 8'd5; in_base_addr = 10'h200; end
      in_word_valid = (!dir && i < n);
      in_word = CW'(first + i);
      in_word_ready = !(stall && c >= 5 && c <= 7);
      @(negedge clk);
      if (out_word_ready && tfr < 0) tfr = cyc;
      if (out_word_valid && tfv < 0) tfv = cyc;
      if (in_word_valid && out_word_ready) i++;
      if (out_done) begin tdone = cyc; fin = 1; end
      @(posedge clk); #1;
    end
    in_start = 0; in_word_valid = 0; in_word_ready = 0;
    chki("done_seen", int'(fin), 1);
    chki("exp_writes_left", exp_wa.size(), 0);
    chki("exp_reads_left", exp_ra.size(), 0);
    chki("exp_words_left", exp_words.size(), 0);
  endtask

  initial begin
    int t0, td, tfr, tfv, nw, nr, nb, nd, n;
    // Reset state
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", W'({out_busy, out_done, out_word_ready, out_word_valid,
                           out_mem_read_en, out_mem_write_en}), '0);
    chk("rst_word", W'(out_word), '0);
    chk("rst_addr", W'(out_mem_address), '0);
    chk("rst_data", out_mem_data, '0);
    @(posedge clk); #3 rst_n = 1;

    // Write 2 lines at 0x010
    nd = done_cnt;
    run_cmd(0, 10'h010, 2, 32'h11, 0, 0, t0, td, tfr, tfv);
    chki("wr_strobes", wr_cyc.size(), 2);
    chk("wr0_addr_lit", W'(wr_addr[0]), W'(10'h010));
    chk("wr1_addr_lit", W'(wr_addr[1]), W'(10'h014));
    chk("wr0_data_lit", wr_data[0], 128'h00000014_00000013_00000012_00000011);
    chk("wr1_data_lit", wr_data[1], 128'h00000018_00000017_00000016_00000015);
    chki("wr_first_ready", tfr - t0, 1);
    chki("wr_line_period", wr_cyc[1] - wr_cyc[0], BL + 1);
    chki("wr_done_after_strobe", td - wr_cyc[1], 1);
    chki("wr_done_pulses", done_cnt - nd, 1);

    // Read back the same 2 lines
    nd = done_cnt;
    run_cmd(1, 10'h010, 2, 0, 0, 0, t0, td, tfr, tfv);
    chki("rd_strobes", rd_cyc.size(), 2);
    chki("rd_strobe_spacing", rd_cyc[1] - rd_cyc[0], 6);
    chki("rd_first_valid", tfv - t0, 3);
    chk("rd_word0_lit", W'(wd_log[0]), W'(32'h11));
    chk("rd_word7_lit", W'(wd_log[7]), W'(32'h18));
    chki("rd_done_pulses", done_cnt - nd, 1);

    // Wrap-around write at 0x3FC
    run_cmd(0, 10'h3FC, 2, 32'h21, 0, 0, t0, td, tfr, tfv);
    chk("wrap_addr0_lit", W'(wr_addr[2]), W'(10'h3FC));
    chk("wrap_addr1_lit", W'(wr_addr[3]), W'(10'h000));

    // Backpressure read across the wrapped lines
    run_cmd(1, 10'h3FC, 2, 0, 1, 0, t0, td, tfr, tfv);
    chki("bp_strobe_spacing", rd_cyc[3] - rd_cyc[2], 9);
    chk("bp_word0_lit", W'(wd_log[8]), W'(32'h21));
    chk("bp_word4_lit", W'(wd_log[12]), W'(32'h25));

    // Zero length
    nw = wr_cyc.size(); nr = rd_cyc.size(); nb = busy_cnt; nd = done_cnt;
    run_cmd(0, 10'h100, 0, 0, 0, 0, t0, td, tfr, tfv);
    chki("zl_done_latency", td - t0, 1);
    chki("zl_busy_cycles", busy_cnt - nb, 1);
    chki("zl_no_strobe", wr_cyc.size() + rd_cyc.size(), nw + nr);
    chki("zl_done_pulses", done_cnt - nd, 1);

    // Reset during FILL after 2 words
    nw = wr_cyc.size();
    @(posedge clk); #1;
    in_start = 1; in_dir = 0; in_base_addr = 10'h040; in_lines = 8'd1;
    @(posedge clk); #1;
    in_start = 0; in_word_valid = 1; in_word = 32'h91; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (out_word_ready) begin n++; in_word = 32'h91 + 32'(n); end
      if (n < 2) begin @(posedge clk); #1; end
    end
    chki("rf_words_taken", n, 2);
    @(posedge clk); #3;
    in_word_valid = 0; rst_n = 0;
    #1;
    chk("rf_ctrl_zero", W'({out_busy, out_done, out_word_ready, out_word_valid,
                            out_mem_read_en, out_mem_write_en}), '0);
    chk("rf_addr_zero", W'(out_mem_address), '0);
    chk("rf_data_zero", out_mem_data, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    chki("rf_no_write", wr_cyc.size(), nw);

    // New command after reset, with an ignored in_start pulse mid-command
    nr = rd_cyc.size(); nd = done_cnt;
    run_cmd(0, 10'h050, 1, 32'h31, 0, 1, t0, td, tfr, tfv);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chki("pr_writes", wr_cyc.size() - nw, 1);
    chk("pr_addr_lit", W'(wr_addr[nw]), W'(10'h050));
    chk("pr_data_lit", wr_data[nw], 128'h00000034_00000033_00000032_00000031);
    chki("pr_no_read", rd_cyc.size(), nr);
    chki("pr_done_pulses", done_cnt - nd, 1);
    chk("pr_idle", W'(out_busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
